// File: rtl/hazard_mdu_ctrl_if.sv
// Decode-stage hazard / HI-LO scheduling bundle between the pipeline and hazard_mdu_ctrl.
// The pipeline (master) drives ID/EX/MEM status; the controller (slave) returns stall and MDU status.
interface hazard_mdu_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      IR_D;
  logic [4:0]       WA_E;
  logic [1:0]       Tnew_E;
  logic [4:0]       WA_M;
  logic [1:0]       Tnew_M;
  logic             md_start;
  logic             md_is_div;
  logic             stall;
  logic             flush_E;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output IR_D, WA_E, Tnew_E, WA_M, Tnew_M, md_start, md_is_div,
    input  stall, flush_E, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  IR_D, WA_E, Tnew_E, WA_M, Tnew_M, md_start, md_is_div,
    output stall, flush_E, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_mdu_ctrl.sv
// Hazard detection for the 5-stage MIPS decode stage: data/HI-LO stalls, mult/div busy
// sequencing and a saturating stall-cycle counter.
module hazard_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input logic              clk,
  input logic              reset,
  hazard_mdu_ctrl_if.slave bus
);

  localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int BC_W    = $clog2(MAX_CYC + 1);

  localparam logic [BC_W-1:0]  MULT_LOAD = BC_W'(MULT_CYCLES);
  localparam logic [BC_W-1:0]  DIV_LOAD  = BC_W'(DIV_CYCLES);
  localparam logic [BC_W-1:0]  BC_ONE    = BC_W'(1);
  localparam logic [BC_W-1:0]  BC_ZERO   = {BC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;
  localparam logic [5:0] FN_MFHI   = 6'b010000;
  localparam logic [5:0] FN_MTHI   = 6'b010001;
  localparam logic [5:0] FN_MFLO   = 6'b010010;
  localparam logic [5:0] FN_MTLO   = 6'b010011;
  localparam logic [5:0] FN_MULT   = 6'b011000;
  localparam logic [5:0] FN_MULTU  = 6'b011001;
  localparam logic [5:0] FN_DIV    = 6'b011010;
  localparam logic [5:0] FN_DIVU   = 6'b011011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // A source is hazardous when a younger producer will not have it ready by the time it is used.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] wa_e,
    input logic [1:0] tnew_e,
    input logic [4:0] wa_m,
    input logic [1:0] tnew_m
  );
    return (src != 5'd0) &&
           (((src == wa_e) && (tnew_e > tuse)) || ((src == wa_m) && (tnew_m > tuse)));
  endfunction

  logic [5:0]       op_s;
  logic [5:0]       fun_s;
  logic [4:0]       rs_s;
  logic [4:0]       rt_s;
  logic             rs_rd_s;
  logic [1:0]       rs_tuse_s;
  logic             rt_rd_s;
  logic [1:0]       rt_tuse_s;
  logic             md_class_s;
  logic             data_stall_s;
  logic             md_stall_s;
  logic             stall_s;
  logic             unused_s;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [BC_W-1:0]  bcnt_r;
  logic [BC_W-1:0]  bcnt_nxt_s;
  logic             done_nxt_s;
  logic             md_busy_r;
  logic             md_done_r;
  logic [CNT_W-1:0] stall_cnt_r;

  assign op_s     = bus.IR_D[31:26];
  assign rs_s     = bus.IR_D[25:21];
  assign rt_s     = bus.IR_D[20:16];
  assign fun_s    = bus.IR_D[5:0];
  assign unused_s = ^bus.IR_D[15:6];

  // Operand read/use-time decode of the instruction in ID.
  always_comb begin
    rs_rd_s   = 1'b1;
    rs_tuse_s = 2'd1;
    rt_rd_s   = 1'b0;
    rt_tuse_s = 2'd1;
    case (op_s)
      OP_RTYPE: begin
        rt_rd_s = 1'b1;
        if ((fun_s == FN_JR) || (fun_s == FN_JALR)) begin
          rs_tuse_s = 2'd0;
        end else begin
          rs_tuse_s = 2'd1;
        end
      end
      OP_BEQ, OP_BNE: begin
        rs_tuse_s = 2'd0;
        rt_rd_s   = 1'b1;
        rt_tuse_s = 2'd0;
      end
      OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        rs_tuse_s = 2'd0;
      end
      OP_SW, OP_SH, OP_SB: begin
        rt_rd_s   = 1'b1;
        rt_tuse_s = 2'd2;
      end
      // Jumps and lui carry immediate bits in the rs field rather than a register number.
      OP_J, OP_JAL, OP_LUI: begin
        rs_rd_s = 1'b0;
      end
      default: begin
        rs_rd_s = 1'b1;
      end
    endcase
  end

  // Instructions that touch HI/LO or start the multi-cycle unit.
  always_comb begin
    md_class_s = 1'b0;
    if (op_s == OP_RTYPE) begin
      case (fun_s)
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
        FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO: md_class_s = 1'b1;
        default:                            md_class_s = 1'b0;
      endcase
    end else begin
      md_class_s = 1'b0;
    end
  end

  assign data_stall_s =
      (rs_rd_s && src_hazard(rs_s, rs_tuse_s, bus.WA_E, bus.Tnew_E, bus.WA_M, bus.Tnew_M)) ||
      (rt_rd_s && src_hazard(rt_s, rt_tuse_s, bus.WA_E, bus.Tnew_E, bus.WA_M, bus.Tnew_M));
  assign md_stall_s = md_class_s && (md_busy_r || bus.md_start);
  assign stall_s    = data_stall_s || md_stall_s;

  assign bus.stall     = stall_s;
  assign bus.flush_E   = stall_s;
  assign bus.md_busy   = md_busy_r;
  assign bus.md_done   = md_done_r;
  assign bus.stall_cnt = stall_cnt_r;

  // Busy-period sequencer next state; a start while busy is ignored.
  always_comb begin
    state_nxt_s = state_r;
    bcnt_nxt_s  = bcnt_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.md_start) begin
          state_nxt_s = ST_BUSY;
          bcnt_nxt_s  = bus.md_is_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
          bcnt_nxt_s  = BC_ZERO;
        end
      end
      ST_BUSY: begin
        bcnt_nxt_s = bcnt_r - BC_ONE;
        if (bcnt_r == BC_ONE) begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_BUSY;
          done_nxt_s  = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        bcnt_nxt_s  = BC_ZERO;
      end
    endcase
  end

  // Sequencer state and its registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bcnt_r    <= BC_ZERO;
      md_busy_r <= 1'b0;
      md_done_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bcnt_r    <= bcnt_nxt_s;
      md_busy_r <= (state_nxt_s == ST_BUSY);
      md_done_r <= done_nxt_s;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= CNT_ZERO;
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: doc/hazard_mdu_ctrl.md
Name: hazard_mdu_ctrl

Overview:
- Pipeline hazard and multiply/divide scheduling controller for the 5-stage MIPS core.
- Watches the instruction in the ID stage against destination registers in EX/MEM and against the multi-cycle HI/LO unit.
- Generates the PC/IF-ID freeze and ID/EX bubble, sequences the mult/div unit's busy period, and keeps a stall-cycle counter.
- Sits beside the decode stage; its outputs drive the PC enable, IF/ID enable and ID/EX clear.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥2).
- DIV_CYCLES, 10, busy cycles for div/divu (≥2).
- CNT_W, 32, width of stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- IR_D  in  32  instruction in ID.
- WA_E  in  5  destination register of EX instruction (0 = none).
- Tnew_E  in  2  cycles until EX result is forwardable: load=2, ALU/link=1, none=0.
- WA_M  in  5  destination register of MEM instruction.
- Tnew_M  in  2  load=1, else 0.
- md_start  in  1  EX holds mult/multu/div/divu this cycle.
- md_is_div  in  1  qualifies md_start: 1=div/divu, 0=mult/multu.
- stall  out  1  freeze PC and IF/ID (combinational).
- flush_E  out  1  insert bubble into ID/EX (equals stall).
- md_busy  out  1  HI/LO unit computing (registered).
- md_done  out  1  one-cycle pulse, first cycle after busy ends (registered).
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset values: md_busy=0, md_done=0, stall_cnt=0, FSM=IDLE, busy counter=0. Reset asserted mid-operation aborts the busy period immediately; no md_done pulse is produced.
- Tuse decode from IR_D (op=IR[31:26], fun=IR[5:0]):
  - rs Tuse=0 for beq(000100), bne(000101), blez(000110), bgtz(000111), REGIMM(000001), and jr/jalr (op 0, fun 001000/001001).
  - rs Tuse=1 for all other instructions reading rs.
  - rt Tuse=0 for beq/bne; 2 for sw/sh/sb (101011/101001/101000); 1 for other op=0 R-type.
  - rt is not read (no hazard) for all other I-type and for j/jal.
- Data stall: for src in {rs=IR_D[25:21], rt=IR_D[20:16]} where src is read, stall if src≠0 and (src==WA_E and Tnew_E>Tuse) or (src==WA_M and Tnew_M>Tuse).
- MDU class in D: op 0 and fun ∈ {011000, 011001, 011010, 011011, 010000, 010010, 010001, 010011}. md_stall = MDU class in D and (md_busy or md_start).
- stall = data stall OR md_stall; flush_E = stall. Both are purely combinational, with no state dependency except md_busy.
- FSM:
  - IDLE: on md_start, go to BUSY and load counter with MULT_CYCLES or DIV_CYCLES per md_is_div.
  - BUSY: decrement the counter each cycle. At counter==1, go to IDLE next edge and set md_done=1 for that one following cycle.
  - md_busy=1 exactly N cycles, starting the cycle after the md_start edge.
  - md_start while BUSY is ignored; it cannot occur legally because of md_stall.
- md_done deasserts after one cycle unless a new busy period ends.
- stall_cnt increments on every edge where stall=1 and holds at all-ones (no wrap).

Test Plan:
- lw $1 in EX (WA_E=1, Tnew_E=2), IR_D=add $3,$1,$2 -> stall=flush_E=1. Next cycle lw in MEM (WA_M=1, Tnew_M=1), WA_E=0 -> stall=0. stall_cnt=1.
- ALU write $5 in EX (Tnew_E=1), IR_D=beq $5,$0 -> stall=1. Same with IR_D=sw $5,0($6) (rt Tuse=2) -> stall=0.
- WA_E=0 and Tnew_E=2, IR_D=add $3,$0,$0 -> stall=0; $0 never hazards.
- md_start=1, md_is_div=0 for one cycle, then IR_D=mflo held -> md_busy high 5 cycles, stall high during those 5 cycles plus the md_start cycle. md_done pulses one cycle after, with stall=0 that cycle.
- DIV start, reset asserted on 4th busy cycle -> md_busy, md_done, stall_cnt immediately 0 and FSM IDLE. After release, mfhi in D -> no stall.
- Force stall=1 for 2^CNT_W+3 cycles with CNT_W=4 -> stall_cnt saturates at 15.
